// File: rtl/hazard_scoreboard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_pkg
// Shared definitions for the hazard scoreboard:
//   - nominal producer latencies (cycles from EX entry until forwardable)
//   - the HAZARD_* optype encoding used by the legacy decoder
//   - a helper mapping a legacy optype onto its nominal latency
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_scoreboard_unit_pkg;

    localparam int unsigned LAT_ALU  = 32'd1;
    localparam int unsigned LAT_LOAD = 32'd2;
    localparam int unsigned LAT_MUL  = 32'd3;
    localparam int unsigned LAT_DIV  = 32'd8;

    // Legacy decode still classifies instructions by optype; new decode
    // drives lat_ID directly, but the encoding is kept for that path.
    typedef enum logic [2:0] {
        HAZARD_NONE   = 3'd0,
        HAZARD_ALU    = 3'd1,
        HAZARD_LOAD   = 3'd2,
        HAZARD_MUL    = 3'd3,
        HAZARD_DIV    = 3'd4,
        HAZARD_STORE  = 3'd5,
        HAZARD_BRANCH = 3'd6
    } hazard_op_e;

    // Nominal latency of a legacy optype (non-producers report ALU latency).
    function automatic int unsigned optype_latency(input hazard_op_e op);
        int unsigned lat;
        case (op)
            HAZARD_LOAD: lat = LAT_LOAD;
            HAZARD_MUL:  lat = LAT_MUL;
            HAZARD_DIV:  lat = LAT_DIV;
            default:     lat = LAT_ALU;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One scoreboard countdown: loads a latency, otherwise decrements towards
// zero, and holds everything while the pipeline is frozen.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (count -> 0)
//   srst     - synchronous soft reset (count -> 0)
//   hold     - freeze: count keeps its value, load ignored
//   load     - load load_val this cycle (wins over decrement)
//   load_val - value to load
//   cnt      - current count
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};

    logic [LAT_W-1:0] cnt_r;

    // Countdown state: reset, freeze, load, or decrement towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (srst) begin
            cnt_r <= CNT_ZERO;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Decode-side hazard detector built on a per-register countdown scoreboard.
// Each tracked register counts the cycles until its pending result becomes
// forwardable; a shared counter tracks occupancy of the multi-cycle unit.
// RAW, WAW and structural hazards stall the instruction in ID and insert a
// bubble into EX. Forward-mux selection is left to the forwarding unit.
// Ports:
//   clk, rst_n            - clock / asynchronous active-low reset
//   issue_valid_ID        - real instruction in ID
//   rs1use_ID, rs2use_ID  - operand actually read
//   rs1_ID, rs2_ID, rd_ID - register indices
//   rd_we_ID              - instruction writes rd
//   lat_ID                - producer latency (0 behaves as 1)
//   mc_ID                 - uses the shared multi-cycle unit
//   store_ID              - instruction is a store (rs2 consumed in MEM)
//   Branch_ID             - taken branch/jump resolved in ID
//   ext_stall             - whole-pipeline freeze
//   PC_EN_IF              - PC update enable
//   reg_FD_stall          - hold IF/ID
//   reg_FD_flush          - clear IF/ID
//   reg_DE_flush          - bubble into ID/EX
//   stall_cycles          - saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int RADDR_W  = 5,
    parameter int LAT_W    = 4,
    parameter int ST_SLACK = 1,
    parameter int STAT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid_ID,
    input  logic               rs1use_ID,
    input  logic               rs2use_ID,
    input  logic [RADDR_W-1:0] rs1_ID,
    input  logic [RADDR_W-1:0] rs2_ID,
    input  logic [RADDR_W-1:0] rd_ID,
    input  logic               rd_we_ID,
    input  logic [LAT_W-1:0]   lat_ID,
    input  logic               mc_ID,
    input  logic               store_ID,
    input  logic               Branch_ID,
    input  logic               ext_stall,
    output logic               PC_EN_IF,
    output logic               reg_FD_stall,
    output logic               reg_FD_flush,
    output logic               reg_DE_flush,
    output logic [STAT_W-1:0]  stall_cycles
);

    localparam logic [LAT_W-1:0]   CNT_ZERO  = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]   CNT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0]   LAT_MIN   = LAT_W'(LAT_ALU);
    localparam logic [RADDR_W-1:0] REG_ZERO  = {RADDR_W{1'b0}};
    // Thresholds are one bit wider so 1+ST_SLACK cannot wrap.
    localparam logic [LAT_W:0]     USE_THR   = (LAT_W+1)'(32'd1);
    localparam logic [LAT_W:0]     STORE_THR = (LAT_W+1)'(32'd1 + 32'(ST_SLACK));
    localparam logic [STAT_W-1:0]  STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0]  STAT_MAX  = {STAT_W{1'b1}};

    logic [LAT_W-1:0]  cnt_s [NREG];
    logic [LAT_W-1:0]  mc_cnt_s;
    logic [LAT_W-1:0]  lat_eff_s;
    logic [LAT_W:0]    rs2_thr_s;
    logic              raw1_s;
    logic              raw2_s;
    logic              waw_s;
    logic              strc_s;
    logic              hz_s;
    logic              iss_s;
    logic [STAT_W-1:0] stall_cycles_r;

    // Register 0 is hardwired zero: never pending.
    assign cnt_s[0] = CNT_ZERO;

    // A zero latency would free the register before the result exists.
    assign lat_eff_s = (lat_ID == CNT_ZERO) ? LAT_MIN : lat_ID;

    // Store data is consumed in MEM, so its rs2 tolerates ST_SLACK more cycles.
    assign rs2_thr_s = store_ID ? STORE_THR : USE_THR;

    // A count of 1 means the result is forwardable next cycle, i.e. in time.
    assign raw1_s = rs1use_ID & (rs1_ID != REG_ZERO) & (cnt_s[rs1_ID] > CNT_ONE);
    assign raw2_s = rs2use_ID & (rs2_ID != REG_ZERO) & ({1'b0, cnt_s[rs2_ID]} > rs2_thr_s);
    // An older, slower write to the same rd must land before this one.
    assign waw_s  = rd_we_ID & (rd_ID != REG_ZERO) & (cnt_s[rd_ID] > lat_eff_s);
    assign strc_s = mc_ID & (mc_cnt_s > CNT_ONE);

    assign hz_s  = issue_valid_ID & (raw1_s | raw2_s | waw_s | strc_s);
    assign iss_s = issue_valid_ID & ~hz_s & ~ext_stall;

    assign reg_FD_stall = hz_s;
    assign PC_EN_IF     = ~hz_s & ~ext_stall;
    assign reg_DE_flush = hz_s & ~ext_stall;
    // A stalled branch flushes only on the cycle it actually issues.
    assign reg_FD_flush = Branch_ID & ~hz_s;

    // Per-register countdowns; index 0 is skipped so rd_ID==0 never loads.
    // There is no soft-reset source at this level, so srst is tied off.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        sb_counter #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .srst     (1'b0),
            .hold     (ext_stall),
            .load     (iss_s & rd_we_ID & (rd_ID == RADDR_W'(r))),
            .load_val (lat_eff_s),
            .cnt      (cnt_s[r])
        );
    end

    // Multi-cycle unit occupancy, loaded whether or not the op writes rd.
    sb_counter #(
        .LAT_W (LAT_W)
    ) u_mc_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (1'b0),
        .hold     (ext_stall),
        .load     (iss_s & mc_ID),
        .load_val (lat_eff_s),
        .cnt      (mc_cnt_s)
    );

    // Saturating count of cycles lost to hazards (frozen cycles excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {STAT_W{1'b0}};
        end else if (hz_s && !ext_stall && (stall_cycles_r != STAT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + STAT_ONE;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Directed scenarios followed by a randomized phase. The reference model keeps,
// for every register and for the multi-cycle unit, the absolute (unfrozen)
// cycle at which the pending result becomes forwardable; remaining latency is
// that time minus the current cycle.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid_ID, rs1use_ID, rs2use_ID, rd_we_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [3:0]  lat_ID;
    logic        mc_ID, store_ID, Branch_ID, ext_stall;
    logic        PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;
    int ready [32];
    int mc_ready;
    int now_c;
    int sc_model;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_ID (issue_valid_ID),
        .rs1use_ID      (rs1use_ID),
        .rs2use_ID      (rs2use_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .rd_ID          (rd_ID),
        .rd_we_ID       (rd_we_ID),
        .lat_ID         (lat_ID),
        .mc_ID          (mc_ID),
        .store_ID       (store_ID),
        .Branch_ID      (Branch_ID),
        .ext_stall      (ext_stall),
        .PC_EN_IF       (PC_EN_IF),
        .reg_FD_stall   (reg_FD_stall),
        .reg_FD_flush   (reg_FD_flush),
        .reg_DE_flush   (reg_DE_flush),
        .stall_cycles   (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int remaining(input int t);
        return (t > now_c) ? (t - now_c) : 0;
    endfunction

    task automatic model_reset();
        foreach (ready[i]) ready[i] = 0;
        mc_ready = 0;
        now_c    = 0;
        sc_model = 0;
    endtask

    task automatic set_ins(input bit v, input bit u1, input int r1, input bit u2, input int r2,
                           input bit we, input int rd, input int lat, input bit mc,
                           input bit st, input bit br);
        issue_valid_ID = v;
        rs1use_ID      = u1;
        rs1_ID         = 5'(r1);
        rs2use_ID      = u2;
        rs2_ID         = 5'(r2);
        rd_we_ID       = we;
        rd_ID          = 5'(rd);
        lat_ID         = 4'(lat);
        mc_ID          = mc;
        store_ID       = st;
        Branch_ID      = br;
    endtask

    // One clock: check all outputs against the model, advance the model.
    task automatic cyc(input string tag, output bit hz_obs);
        int  l;
        bit  raw1, raw2, waw, strc, hz, iss;
        #3;
        l    = (lat_ID == 4'd0) ? 1 : int'(lat_ID);
        raw1 = rs1use_ID && (rs1_ID != 5'd0) && (remaining(ready[rs1_ID]) > 1);
        raw2 = rs2use_ID && (rs2_ID != 5'd0) && (remaining(ready[rs2_ID]) > (store_ID ? 2 : 1));
        waw  = rd_we_ID && (rd_ID != 5'd0) && (remaining(ready[rd_ID]) > l);
        strc = mc_ID && (remaining(mc_ready) > 1);
        hz   = issue_valid_ID && (raw1 || raw2 || waw || strc);
        check({tag, ".fd_stall"}, 32'(reg_FD_stall), 32'(hz));
        check({tag, ".pc_en"},    32'(PC_EN_IF),     32'(!hz && !ext_stall));
        check({tag, ".de_flush"}, 32'(reg_DE_flush), 32'(hz && !ext_stall));
        check({tag, ".fd_flush"}, 32'(reg_FD_flush), 32'(Branch_ID && !hz));
        check({tag, ".stat"},     32'(stall_cycles), 32'(sc_model));
        hz_obs = reg_FD_stall;
        if (!ext_stall) begin
            iss = issue_valid_ID && !hz;
            if (hz && sc_model < 65535) sc_model++;
            if (iss && rd_we_ID && rd_ID != 5'd0) ready[rd_ID] = now_c + 1 + l;
            if (iss && mc_ID) mc_ready = now_c + 1 + l;
            now_c++;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold the current instruction in ID until it issues; count stall cycles.
    task automatic issue(input string tag, input int budget, output int stalls);
        bit h;
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cyc(tag, h);
            if (h) stalls++;
            else   done = 1'b1;
        end
        tests++;
        assert (done)
        else begin
            fails++;
            $error("FAIL %s.timeout observed=stalled expected=issue within %0d", tag, budget);
        end
    endtask

    task automatic idle(input int n);
        bit h;
        set_ins(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc("idle", h);
    endtask

    initial begin
        int s;
        int sc_before;
        bit h;

        model_reset();
        rst_n     = 1'b0;
        ext_stall = 1'b0;
        set_ins(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #12;
        check("rst.pc_en",    32'(PC_EN_IF),     32'd1);
        check("rst.fd_stall", 32'(reg_FD_stall), 32'd0);
        check("rst.fd_flush", 32'(reg_FD_flush), 32'd0);
        check("rst.de_flush", 32'(reg_DE_flush), 32'd0);
        check("rst.stat",     32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // load x5 ; add x6,x5,x1 -> one bubble
        set_ins(1, 1, 1, 0, 0, 1, 5, 2, 0, 0, 0);
        issue("ld_x5", 4, s);
        set_ins(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        issue("add_x6", 6, s);
        check("load_use.bubbles", 32'(s), 32'd1);
        check("load_use.stat", 32'(stall_cycles), 32'd1);
        idle(4);

        // add x5 ; sub x7,x5,x5 -> no bubble
        set_ins(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        issue("add_x5", 4, s);
        set_ins(1, 1, 5, 1, 5, 1, 7, 1, 0, 0, 0);
        issue("sub_x7", 4, s);
        check("alu_use.bubbles", 32'(s), 32'd0);
        idle(4);

        // div x8 ; add x9,x8,x0 -> seven bubbles
        set_ins(1, 1, 1, 1, 2, 1, 8, 8, 1, 0, 0);
        issue("div_x8", 4, s);
        set_ins(1, 1, 8, 1, 0, 1, 9, 1, 0, 0, 0);
        issue("add_x9", 12, s);
        check("div_use.bubbles", 32'(s), 32'd7);
        idle(10);

        // div x10 ; div x11 back-to-back -> structural stall
        set_ins(1, 1, 1, 1, 2, 1, 10, 8, 1, 0, 0);
        issue("div_x10", 4, s);
        set_ins(1, 1, 1, 1, 2, 1, 11, 8, 1, 0, 0);
        issue("div_x11", 12, s);
        check("div_div.bubbles", 32'(s), 32'd7);
        idle(10);

        // load x3 ; sw x3 as data -> slack absorbs the load
        set_ins(1, 1, 1, 0, 0, 1, 3, 2, 0, 0, 0);
        issue("ld_x3a", 4, s);
        set_ins(1, 1, 2, 1, 3, 0, 0, 1, 0, 1, 0);
        issue("sw_data", 4, s);
        check("store_data.bubbles", 32'(s), 32'd0);
        idle(4);

        // load x3 ; sw with x3 as address -> one bubble
        set_ins(1, 1, 1, 0, 0, 1, 3, 2, 0, 0, 0);
        issue("ld_x3b", 4, s);
        set_ins(1, 1, 3, 1, 2, 0, 0, 1, 0, 1, 0);
        issue("sw_addr", 4, s);
        check("store_addr.bubbles", 32'(s), 32'd1);
        idle(4);

        // div x4 ; addi x4 -> WAW stall, then x4 ready right away
        set_ins(1, 1, 1, 1, 2, 1, 4, 8, 1, 0, 0);
        issue("div_x4", 4, s);
        set_ins(1, 1, 1, 0, 0, 1, 4, 1, 0, 0, 0);
        issue("addi_x4", 12, s);
        check("waw.bubbles", 32'(s), 32'd7);
        set_ins(1, 1, 4, 0, 0, 1, 15, 1, 0, 0, 0);
        issue("use_x4", 4, s);
        check("waw_after.bubbles", 32'(s), 32'd0);
        idle(4);

        // taken branch with no hazard flushes at once
        set_ins(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("br_free", h);
        check("br_free.issued", 32'(h), 32'd0);
        // branch depending on a load stalls one cycle, flushes on issue
        set_ins(1, 1, 1, 0, 0, 1, 5, 2, 0, 0, 0);
        issue("ld_x5b", 4, s);
        set_ins(1, 1, 5, 1, 0, 0, 0, 1, 0, 0, 1);
        issue("br_dep", 4, s);
        check("br_dep.bubbles", 32'(s), 32'd1);
        idle(4);

        // lat 0 behaves as ALU latency
        set_ins(1, 1, 1, 0, 0, 1, 14, 0, 0, 0, 0);
        issue("lat0_x14", 4, s);
        set_ins(1, 1, 14, 0, 0, 1, 16, 1, 0, 0, 0);
        issue("use_x14", 4, s);
        check("lat0.bubbles", 32'(s), 32'd0);
        idle(4);

        // pending hazard frozen by ext_stall, then reset mid-stall
        set_ins(1, 1, 1, 1, 2, 1, 12, 8, 1, 0, 0);
        issue("div_x12", 4, s);
        set_ins(1, 1, 12, 1, 0, 1, 13, 1, 0, 0, 0);
        cyc("cons1", h);
        cyc("cons2", h);
        sc_before = sc_model;
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("frozen", h);
        check("frozen.stat", 32'(stall_cycles), 32'(sc_before));
        ext_stall = 1'b0;
        cyc("thaw", h);
        check("thaw.still_stalled", 32'(h), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.fd_stall", 32'(reg_FD_stall), 32'd0);
        check("midrst.pc_en",    32'(PC_EN_IF),     32'd1);
        check("midrst.de_flush", 32'(reg_DE_flush), 32'd0);
        check("midrst.stat",     32'(stall_cycles), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue("cons_after_rst", 4, s);
        check("after_rst.bubbles", 32'(s), 32'd0);
        idle(4);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_ins($urandom_range(0, 9) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    $urandom_range(0, 9),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0);
            ext_stall = ($urandom_range(0, 9) == 0);
            cyc("rnd", h);
        end
        ext_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the fixed 5-stage hazard detector. It tracks every architectural register with a per-register countdown scoreboard, so variable-latency producers are handled uniformly: 1-cycle ALU, 2-cycle load, and multi-cycle mul/div.
- Generates IF/ID/EX stall, bubble and flush controls; sits beside the decode stage.
- Forward-mux selects remain the job of the companion forwarding unit; this block only decides when an operand can be consumed.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- RADDR_W, 5, register index width; must equal clog2(NREG).
- LAT_W, 4, width of latency field and scoreboard counters; max latency is 2^LAT_W-1.
- ST_SLACK, 1, extra cycles a store's rs2 may still be pending, because store data is consumed in MEM, not EX.
- STAT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- issue_valid_ID, in, 1, a real (non-bubble) instruction is in ID.
- rs1use_ID, rs2use_ID, in, 1 each, operand actually read.
- rs1_ID, rs2_ID, rd_ID, in, RADDR_W each, register indices.
- rd_we_ID, in, 1, instruction writes rd.
- lat_ID, in, LAT_W, cycles from EX entry until result is forwardable; 1=ALU, 2=load, >2=multi-cycle.
- mc_ID, in, 1, instruction uses the shared multi-cycle unit.
- store_ID, in, 1, instruction is a store.
- Branch_ID, in, 1, taken branch/jump resolved in ID.
- ext_stall, in, 1, whole-pipeline freeze (memory miss).
- PC_EN_IF, out, 1, PC update enable.
- reg_FD_stall, out, 1, hold IF/ID register.
- reg_FD_flush, out, 1, clear IF/ID register.
- reg_DE_flush, out, 1, insert bubble into ID/EX.
- stall_cycles, out, STAT_W, saturating count of hazard-stall cycles.

Behaviour:
- State:
  - cnt[1..NREG-1], LAT_W each.
  - mc_cnt, LAT_W, remaining busy cycles of the multi-cycle unit.
  - stall_cycles.
- Reset (async, rst_n=0): all cnt=0, mc_cnt=0, stall_cycles=0. Outputs during and after reset until a hazard: PC_EN_IF=1, reg_FD_stall=0, reg_FD_flush=0, reg_DE_flush=0.
- RAW stall (combinational):
  - raw1 = rs1use_ID & rs1_ID!=0 & cnt[rs1_ID]>1.
  - raw2 = rs2use_ID & rs2_ID!=0 & cnt[rs2_ID] > (store_ID ? 1+ST_SLACK : 1).
- WAW stall: waw = rd_we_ID & rd_ID!=0 & cnt[rd_ID] > lat_ID. An older, slower write must not overtake.
- Structural stall: strc = mc_ID & mc_cnt>1.
- hz = issue_valid_ID & (raw1|raw2|waw|strc).
- Control outputs:
  - reg_FD_stall = hz.
  - PC_EN_IF = ~hz & ~ext_stall.
  - reg_DE_flush = hz & ~ext_stall.
  - reg_FD_flush = Branch_ID & ~hz. A stalled branch is not flushed yet; it flushes on the cycle it issues.
- Issue event: iss = issue_valid_ID & ~hz & ~ext_stall.
- Per-register update when ext_stall=0:
  - if iss & rd_we_ID & rd_ID==r, cnt[r] <= lat_ID (load wins over decrement);
  - else if cnt[r]!=0, cnt[r] <= cnt[r]-1.
- When ext_stall=1: all counters hold and no issue occurs.
- mc_cnt follows the same rule, loaded with lat_ID when iss & mc_ID, regardless of rd_we_ID.
- rd_ID==0 never loads the scoreboard.
- lat_ID==0 is treated as 1.
- stall_cycles increments when hz & ~ext_stall, and saturates at all-ones.
- Timing examples:
  - Load then dependent use: exactly 1 bubble.
  - ALU then use: 0 bubbles.
  - Div with lat=8 then use: 7 bubbles.
- Reset asserted mid-stall clears the scoreboard immediately; the pending hazard is dropped.

Decomposition:
- Shared package holds:
  - latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3, LAT_DIV=8;
  - the HAZARD_* optype encoding, kept for legacy decode.
- One sub-module, sb_counter: a single LAT_W countdown with load/decrement/hold and async reset. It is instantiated NREG-1 times for the registers plus once for mc_cnt.

Test Plan:
- Reset, then load x5 (lat 2) followed by add x6,x5,x1 → reg_FD_stall=1 and reg_DE_flush=1 for exactly 1 cycle; PC_EN_IF=0 that cycle; stall_cycles=1.
- add x5 then sub x7,x5,x5 back-to-back → no stall; cnt[5] goes 1 then 0.
- div x8 (lat 8, mc) then add x9,x8,x0 → 7 stall cycles. A second div issued immediately also stalls until mc_cnt≤1.
- load x3 then sw x3 (store_ID, rs2=x3) → 0 stalls with ST_SLACK=1. Same sequence with rs1=x3 → 1 stall.
- div x4 then addi x4 (lat 1) → WAW stall until cnt[4]≤1; the addi then loads cnt[4]=1.
- Pending hazard with ext_stall=1 for 3 cycles → counters frozen, stall_cycles unchanged. Then rst_n pulsed low mid-stall → all cnt=0, stall deasserts asynchronously.
